// File: rtl/ctrl_encoder.sv
// ctrl_encoder
// Encodes abstract commands into {op_ext[1:0], opcode[4:0]} instruction words and buffers
// them in a 2-entry FIFO for the decoder-side consumer.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_kind, cmd_sub, cmd_raw      command payload
//   resume                          pulse: leave HALTED once the FIFO has drained
//   err_clr                         clears the sticky illegal-command flag
//   instr_valid/instr_ready         instruction handshake (FIFO head)
//   opcode0..4, op_ext0..1          head word bits, 0 when empty
//   halted, err, issued_cnt         status
module ctrl_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_kind,
  input  logic [1:0]       cmd_sub,
  input  logic [6:0]       cmd_raw,
  input  logic             resume,
  input  logic             err_clr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             opcode0,
  output logic             opcode1,
  output logic             opcode2,
  output logic             opcode3,
  output logic             opcode4,
  output logic             op_ext0,
  output logic             op_ext1,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [6:0]       mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] issued_q;

  logic       accept, legal, push, pop;
  logic [6:0] enc_word;
  logic [6:0] head_word;

  assign cmd_ready = (state_q == StRun) && (count_q < 2'd2);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_kind <= 4'd5);
  assign push      = accept && legal;
  assign instr_valid = (count_q != 2'd0);
  assign pop       = instr_valid && instr_ready;

  // Word layout is {op_ext1, op_ext0, opcode4..opcode0}.
  always_comb begin
    enc_word = 7'b0;
    unique case (cmd_kind)
      4'd0:    enc_word = 7'b00_00000;
      4'd1:    enc_word = {6'b00_0010, cmd_sub[0]};
      4'd2:    enc_word = {5'b00_011, cmd_sub[1], cmd_sub[0]};
      4'd3:    enc_word = 7'b00_10000;
      4'd4:    enc_word = 7'b00_10001;
      4'd5:    enc_word = cmd_raw;
      default: enc_word = 7'b0;
    endcase
  end

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (accept && cmd_kind == 4'd0) state_d = StHalted;
      StHalted: if (resume && count_q == 2'd0) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // Illegal acceptance wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (accept && !legal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      mem_q[0] <= 7'b0;
      mem_q[1] <= 7'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        mem_q[wr_ptr_q] <= enc_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  assign head_word = instr_valid ? mem_q[rd_ptr_q] : 7'b0;

  assign opcode0    = head_word[0];
  assign opcode1    = head_word[1];
  assign opcode2    = head_word[2];
  assign opcode3    = head_word[3];
  assign opcode4    = head_word[4];
  assign op_ext0    = head_word[5];
  assign op_ext1    = head_word[6];
  assign halted     = (state_q == StHalted);
  assign err        = err_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_ctrl_encoder.sv
module tb_ctrl_encoder;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_kind;
  logic [1:0]      cmd_sub;
  logic [6:0]      cmd_raw;
  logic            resume;
  logic            err_clr;
  logic            instr_valid;
  logic            instr_ready;
  logic            opcode0, opcode1, opcode2, opcode3, opcode4;
  logic            op_ext0, op_ext1;
  logic            halted;
  logic            err;
  logic [CntW-1:0] issued_cnt;

  logic [6:0] head;
  assign head = {op_ext1, op_ext0, opcode4, opcode3, opcode2, opcode1, opcode0};

  int n_checks = 0;
  int n_fails  = 0;

  ctrl_encoder #(.CNT_W(CntW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_kind    (cmd_kind),
    .cmd_sub     (cmd_sub),
    .cmd_raw     (cmd_raw),
    .resume      (resume),
    .err_clr     (err_clr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode0     (opcode0),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .opcode3     (opcode3),
    .opcode4     (opcode4),
    .op_ext0     (op_ext0),
    .op_ext1     (op_ext1),
    .halted      (halted),
    .err         (err),
    .issued_cnt  (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] kind, input logic [1:0] sub);
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_sub   = sub;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 4'd0; cmd_sub = 2'd0; cmd_raw = 7'd0;
    resume = 1'b0; err_clr = 1'b0; instr_ready = 1'b0;
    #12;
    check("rst_valid", instr_valid, 0);
    check("rst_head", head, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_cnt", issued_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back stream at full throughput.
    instr_ready = 1'b1;
    offer(4'd1, 2'b01);
    #1 check("no_bypass", instr_valid, 0);
    step(); check("s_jump", head, 7'b00_00101); check("s_jump_v", instr_valid, 1);
    offer(4'd2, 2'b10);
    step(); check("s_branch", head, 7'b00_01110); check("s_rdy", cmd_ready, 1);
    offer(4'd3, 2'b00);
    step(); check("s_store", head, 7'b00_10000);
    offer(4'd4, 2'b00);
    step(); check("s_load", head, 7'b00_10001);
    cmd_valid = 1'b0;
    step(); check("s_empty", instr_valid, 0); check("s_cnt", issued_cnt, 4);

    // Backpressure: FIFO fills, head holds, then drains in order.
    instr_ready = 1'b0;
    offer(4'd3, 2'b00);
    step(); check("bp_head1", head, 7'b00_10000);
    offer(4'd4, 2'b00);
    step(); check("bp_full_rdy", cmd_ready, 0); check("bp_head2", head, 7'b00_10000);
    offer(4'd1, 2'b00);
    step(); check("bp_stall_rdy", cmd_ready, 0); check("bp_head3", head, 7'b00_10000);
    instr_ready = 1'b1;
    #1 check("bp_rdy_indep", cmd_ready, 0);
    step(); check("bp_d1", head, 7'b00_10001); check("bp_d1_rdy", cmd_ready, 1);
    step(); check("bp_d2", head, 7'b00_00100);
    cmd_valid = 1'b0;
    step(); check("bp_empty", instr_valid, 0); check("bp_cnt", issued_cnt, 7);

    // HALT blocks further commands until resume with an empty FIFO.
    instr_ready = 1'b0;
    offer(4'd0, 2'b00);
    step(); check("h_halted", halted, 1); check("h_rdy", cmd_ready, 0);
    check("h_word_v", instr_valid, 1); check("h_word", head, 7'b0);
    offer(4'd2, 2'b00);
    step(); check("h_stall", head, 7'b0);
    resume = 1'b1;
    step(); resume = 1'b0; check("h_res_ign", halted, 1);
    instr_ready = 1'b1;
    step(); check("h_drain", instr_valid, 0); check("h_still", halted, 1);
    check("h_rdy2", cmd_ready, 0);
    resume = 1'b1;
    step(); resume = 1'b0; check("h_run", halted, 0); check("h_rdy3", cmd_ready, 1);
    step(); check("h_branch", head, 7'b00_01100);
    cmd_valid = 1'b0;
    step(); check("h_cnt", issued_cnt, 9);

    // Illegal command handling and err priority.
    offer(4'd9, 2'b00);
    #1 check("ill_rdy", cmd_ready, 1);
    step(); check("ill_err", err, 1); check("ill_nopush", instr_valid, 0);
    err_clr = 1'b1;
    step(); check("ill_setwins", err, 1);
    cmd_valid = 1'b0;
    step(); check("ill_clr", err, 0);
    err_clr = 1'b0;

    // RAW passthrough.
    cmd_valid = 1'b1; cmd_kind = 4'd5; cmd_raw = 7'b1011011;
    step(); check("raw_word", head, 7'b1011011);
    check("raw_ext1", op_ext1, 1); check("raw_ext0", op_ext0, 0);
    cmd_valid = 1'b0;
    step(); check("raw_cnt", issued_cnt, 10);

    // Asynchronous reset with two entries pending.
    instr_ready = 1'b0;
    offer(4'd3, 2'b00);
    step(); step();
    cmd_valid = 1'b0;
    check("pre_rst_full", cmd_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", instr_valid, 0);
    check("arst_head", head, 0);
    check("arst_cnt", issued_cnt, 0);
    check("arst_rdy", cmd_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Counter wrap at CNT_W = 4.
    instr_ready = 1'b1;
    offer(4'd4, 2'b00);
    for (int i = 0; i < 17; i++) step();
    cmd_valid = 1'b0;
    step(); check("wrap_cnt", issued_cnt, 1); check("wrap_empty", instr_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ctrl_encoder.md
# ctrl_encoder

Instruction-word encoder: the counterpart of the control decoder. Accepts abstract commands over a valid/ready handshake, encodes each into the 5-bit opcode plus 2-bit op_ext fields, and buffers them in a 2-entry FIFO. The FIFO feeds the decoder-side consumer over a second valid/ready handshake. A sticky halt state blocks new commands after a HALT until software resumes. The block also counts issued instructions and flags illegal commands.

## Interface
- CNT_W, 16, width of issued-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
- cmd_kind  in  4  0 HALT, 1 JUMP, 2 BRANCH, 3 STORE, 4 LOAD, 5 RAW, 6–15 illegal
- cmd_sub  in  2  variant select (JUMP/BRANCH)
- cmd_raw  in  7  raw word for RAW: bits [4:0] = opcode4..0, bits [6:5] = op_ext1..0
- resume  in  1  single-cycle pulse, leave HALTED
- err_clr  in  1  clears err
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  consumer accepts head
- opcode0, opcode1, opcode2, opcode3, opcode4  out  1 each  head opcode bits
- op_ext0, op_ext1  out  1 each  head op_ext bits
- halted  out  1  state == HALTED
- err  out  1  sticky illegal-command flag
- issued_cnt  out  CNT_W  count of completed instr handshakes

## Operation
- Encoding, written as {opcode4,opcode3,opcode2,opcode1,opcode0}. op_ext = 00 unless RAW.
  - HALT: 00000.
  - JUMP: {0,0,1,0,cmd_sub[0]}. sub[0]=1 selects register base (sel_pc_opA); 0 selects PC-relative.
  - BRANCH: {0,1,1,cmd_sub[1],cmd_sub[0]}. 00 beqz, 01 bnez, 10 bltz, 11 bgez.
  - STORE: 10000.
  - LOAD: 10001.
  - RAW: opcode = cmd_raw[4:0], op_ext = cmd_raw[6:5]. Passed through unchecked. A RAW 00000 is not treated as HALT by this block.
- Illegal kind (6–15):
  - The handshake completes and nothing is pushed.
  - err sets on the next edge.
- FIFO:
  - 2 entries, 7 bits each, with a count of 0..2.
  - cmd_ready = (state==RUN) & (count<2). cmd_ready never depends on instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head outputs are driven to 0 when empty.
- State machine with states RUN and HALTED:
  - RUN→HALTED on acceptance of a HALT command. The HALT word is still pushed and drains normally.
  - HALTED→RUN on the edge where resume=1 and count==0.
  - resume while count≠0, or while in RUN, is ignored and not remembered.
- err:
  - Set by illegal acceptance, cleared by err_clr.
  - Set wins if both occur in the same cycle.
- issued_cnt increments on each instr_valid & instr_ready edge and wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync-safe deassert):
  - count=0 and state=RUN.
  - err=0, issued_cnt=0.
  - instr_valid=0, all opcode/op_ext outputs 0.
  - halted=0, cmd_ready=1.
- Latency: a command accepted at edge N produces instr_valid=1 in the cycle after edge N. There is no combinational bypass from cmd_* to instr_*.
- instr_valid=1 with the head word held stable until the handshake; no retraction.
- Full throughput of 1 instr/cycle is sustained when instr_ready is held 1.
- halted is registered and rises in the cycle after the HALT acceptance edge. cmd_ready drops at that same point.
- Reset mid-operation discards FIFO contents immediately; no partial handshake survives.

## Test plan
- Reset, then JUMP sub=01, BRANCH sub=10, STORE, LOAD with instr_ready=1 -> words {00101,01110,10000,10001}, op_ext=00, one per cycle starting 1 cycle after first accept; issued_cnt=4.
- instr_ready=0, offer 3 commands -> first two accepted, cmd_ready=0 with count=2; head stable. Raise instr_ready -> in-order drain and the third is accepted.
- HALT then a BRANCH offered continuously -> halted=1 the next cycle, BRANCH stalled. HALT word 00000 emitted. resume while FIFO is non-empty is ignored; resume after drain -> RUN, BRANCH accepted.
- cmd_kind=9 -> accepted, no instr_valid, err=1. err_clr and a second illegal in the same cycle -> err stays 1. err_clr alone -> 0.
- RAW cmd_raw=7'b1011011 -> opcode 11011, op_ext1=1, op_ext0=0. CNT_W=4: 17 issues -> issued_cnt=1 (wrap).
- Assert rst_n=0 with 2 entries pending -> instr_valid=0 and counters 0 immediately, without waiting for a clk edge.
